// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: state encoding and default delays shared by the UART TX/RX command controllers
package uart_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    REGISTER  = 4'd1,
    SEND_LSB  = 4'd2,
    DELAY_LSB = 4'd3,
    SEND_MSB  = 4'd4,
    DELAY_MSB = 4'd5
  } state_t;
  localparam int DEF_INTER_BYTE_DELAY = 1000000;
  localparam int DEF_WAIT_FOR_REGISTER_DELAY = 100;
endpackage

// File: rtl/state_hold_timer.sv
// state_hold_timer: counts cycles spent in the current state, cleared on every state change
module state_hold_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  output logic [31:0] count
);
  // free-running wrap-around count; a clear restarts it at zero for the new state
  always_ff @(posedge clk)
    count <= (reset || clear) ? '0 : count + 32'd1;
endmodule

// File: rtl/uart_tx_ctrl_result.sv
// uart_tx_ctrl_result: sends a captured 16-bit result as two UART bytes, LSB first
module uart_tx_ctrl_result
  import uart_ctrl_pkg::*;
#(
  parameter int INTER_BYTE_DELAY = DEF_INTER_BYTE_DELAY,
  parameter int WAIT_FOR_REGISTER_DELAY = DEF_WAIT_FOR_REGISTER_DELAY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [15:0] data_in,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  LED
);
  state_t state, next_state;
  logic [15:0] result;
  logic [31:0] timer;
  logic reg_ok, byte_ok;

  assign reg_ok = timer >= 32'(WAIT_FOR_REGISTER_DELAY);
  assign byte_ok = timer >= 32'(INTER_BYTE_DELAY);

  state_hold_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (next_state != state),
    .count (timer)
  );

  // next-state decode; any unlisted encoding falls back to IDLE
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:      next_state = trigger ? REGISTER : IDLE;
      REGISTER:  next_state = reg_ok ? SEND_LSB : REGISTER;
      SEND_LSB:  next_state = tx_busy ? SEND_LSB : DELAY_LSB;
      DELAY_LSB: next_state = byte_ok ? SEND_MSB : DELAY_LSB;
      SEND_MSB:  next_state = tx_busy ? SEND_MSB : DELAY_MSB;
      DELAY_MSB: next_state = byte_ok ? IDLE : DELAY_MSB;
      default:   next_state = IDLE;
    endcase
  end

  // state register and result capture, which only happens on a trigger accepted in IDLE
  always_ff @(posedge clk)
    if (reset) begin
      state  <= IDLE;
      result <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && trigger) result <= data_in;
    end

  assign tx_start = (state == SEND_LSB || state == SEND_MSB) && !tx_busy;
  assign tx_data  = (state == SEND_LSB || state == DELAY_LSB) ? result[7:0] :
                    (state == SEND_MSB || state == DELAY_MSB) ? result[15:8] : 8'h00;
  assign busy     = state != IDLE;
  assign done     = state == DELAY_MSB && byte_ok;
  assign LED      = state;
endmodule
